// File: rtl/result_writeback_if.sv
// Avalon-MM write-only bus used by the result writeback block.
// The master drives address/write/writedata, and the slave stalls with waitrequest.
interface result_writeback_if;
    logic [31:0] address;
    logic        write;
    logic [31:0] writedata;
    logic        waitrequest;

    modport master (
        output address,
        output write,
        output writedata,
        input  waitrequest
    );

    modport slave (
        input  address,
        input  write,
        input  writedata,
        output waitrequest
    );
endinterface

// File: rtl/result_writeback.sv
// Captures a matmul result vector plus its reported sum, then writes it out over Avalon-MM.
// It also checks the reported sum against a running accumulation of the written elements.
module result_writeback #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned RES_WIDTH = 24,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [RES_WIDTH-1:0] c_vector [0:DEPTH-1],
    input  logic [RES_WIDTH-1:0] sum,
    result_writeback_if.master   bus,
    output logic                 busy,
    output logic                 done,
    output logic                 sum_err
);

    localparam int unsigned      IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [31:0]      SUM_ADDR = BASE_ADDR + 32'(4 * DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WR_ELEM,
        WR_SUM,
        FINISH
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     index_q, index_d;
    logic [RES_WIDTH-1:0] acc_q, acc_d;
    logic                 sum_err_q, sum_err_d;
    logic [RES_WIDTH-1:0] snap_q [0:DEPTH-1];
    logic [RES_WIDTH-1:0] snap_d [0:DEPTH-1];
    logic [RES_WIDTH-1:0] sum_snap_q, sum_snap_d;

    // Control state; reset abandons any transfer in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            index_q   <= '0;
            acc_q     <= '0;
            sum_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            acc_q     <= acc_d;
            sum_err_q <= sum_err_d;
        end
    end

    // Snapshot storage: it only ever loads on a capture, so it needs no reset.
    always_ff @(posedge clk) begin
        snap_q     <= snap_d;
        sum_snap_q <= sum_snap_d;
    end

    // Sequencing: capture, one element per accepted write, then the sum, then the checksum verdict.
    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        acc_d      = acc_q;
        sum_err_d  = sum_err_q;
        snap_d     = snap_q;
        sum_snap_d = sum_snap_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d     = c_vector;
                    sum_snap_d = sum;
                    index_d    = '0;
                    acc_d      = '0;
                    sum_err_d  = 1'b0;
                    state_d    = WR_ELEM;
                end
            end
            WR_ELEM: begin
                if (!bus.waitrequest) begin
                    acc_d = acc_q + snap_q[index_q];
                    if (index_q == LAST_IDX) begin
                        index_d = '0;
                        state_d = WR_SUM;
                    end else begin
                        index_d = index_q + IDX_W'(1);
                    end
                end
            end
            WR_SUM: begin
                if (!bus.waitrequest) begin
                    sum_err_d = (acc_q != sum_snap_q);
                    state_d   = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus outputs decode from registered state alone, so they hold steady through stalls.
    always_comb begin
        bus.write     = 1'b0;
        bus.address   = '0;
        bus.writedata = '0;
        done          = 1'b0;
        unique case (state_q)
            WR_ELEM: begin
                bus.write     = 1'b1;
                bus.address   = BASE_ADDR + (32'(index_q) << 2);
                bus.writedata = 32'(snap_q[index_q]);
            end
            WR_SUM: begin
                bus.write     = 1'b1;
                bus.address   = SUM_ADDR;
                bus.writedata = 32'(sum_snap_q);
            end
            FINISH: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign sum_err = sum_err_q;

endmodule

// File: tb/tb_result_writeback.sv
// Scoreboard bench for result_writeback: expected writes are queued at start
// and popped as the bus accepts them; a per-address stall plan drives waitrequest.
module tb_result_writeback;

    localparam int DEPTH = 8;
    localparam int RW    = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [RW-1:0] cv [0:DEPTH-1];
    logic [RW-1:0] sum_in;
    logic          busy;
    logic          done;
    logic          sum_err;

    result_writeback_if bus ();

    result_writeback #(
        .DEPTH     (DEPTH),
        .RES_WIDTH (RW),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .c_vector (cv),
        .sum      (sum_in),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .sum_err  (sum_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int n_wr   = 0;

    logic [63:0] exp_q [$];

    int          stall_left = 0;
    logic [31:0] stall_addr = 32'hFFFF_FFFF;
    logic        held       = 1'b0;
    logic [31:0] h_addr;
    logic [31:0] h_data;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Drives waitrequest from the stall plan and retires accepted writes against the queue.
    always @(negedge clk) begin
        logic [63:0] e;
        if (held && bus.write) begin
            check("hold_addr", bus.address, h_addr);
            check("hold_data", bus.writedata, h_data);
        end
        held = 1'b0;
        if (bus.write && bus.address == stall_addr && stall_left > 0) begin
            bus.waitrequest = 1'b1;
            stall_left--;
            held   = 1'b1;
            h_addr = bus.address;
            h_data = bus.writedata;
        end else begin
            bus.waitrequest = 1'b0;
            if (bus.write) begin
                n_wr++;
                if (exp_q.size() == 0) begin
                    check("spurious_wr", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", bus.address, e[63:32]);
                    check("wr_data", bus.writedata, e[31:0]);
                end
            end
        end
    end

    task automatic push_exp(input logic [RW-1:0] s);
        for (int i = 0; i < DEPTH; i++)
            exp_q.push_back({32'(4 * i), 32'(cv[i])});
        exp_q.push_back({32'(4 * DEPTH), 32'(s)});
    endtask

    task automatic pulse_start();
        @(negedge clk); #2;
        start = 1'b1;
        @(negedge clk); #2;
        start = 1'b0;
    endtask

    task automatic run(input logic [RW-1:0] s, input int stalls,
                       input logic exp_err, input logic glitch);
        int   t0;
        logic seen;
        n_wr   = 0;
        sum_in = s;
        push_exp(s);
        @(negedge clk); #2;
        start = 1'b1;
        t0    = cyc;
        @(negedge clk); #2;
        start = 1'b0;
        if (glitch) begin
            repeat (2) @(negedge clk);
            #2;
            start  = 1'b1;
            sum_in = '0;
            for (int i = 0; i < DEPTH; i++) cv[i] = 24'hABCDEF;
            @(negedge clk); #2;
            start = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #2;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("latency", 32'(cyc - t0), 32'(DEPTH + 2 + stalls));
            check("sum_err", 32'(sum_err), 32'(exp_err));
            check("busy_fin", 32'(busy), 32'd1);
            check("write_fin", 32'(bus.write), 32'd0);
            check("n_wr", 32'(n_wr), 32'(DEPTH + 1));
            check("q_empty", 32'(exp_q.size()), 32'd0);
            @(negedge clk); #2;
            check("done_pulse", 32'(done), 32'd0);
            check("busy_idle", 32'(busy), 32'd0);
            check("idle_addr", bus.address, 32'd0);
            check("idle_data", bus.writedata, 32'd0);
            repeat (3) @(negedge clk);
            check("err_held", 32'(sum_err), 32'(exp_err));
        end
        exp_q.delete();
    endtask

    task automatic ramp();
        for (int i = 0; i < DEPTH; i++) cv[i] = RW'(i + 1);
    endtask

    initial begin
        logic seen;
        rst    = 1'b1;
        start  = 1'b0;
        sum_in = '0;
        for (int i = 0; i < DEPTH; i++) cv[i] = '0;
        repeat (3) @(negedge clk);
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_write", 32'(bus.write), 32'd0);
        check("rst_addr", bus.address, 32'd0);
        check("rst_err", 32'(sum_err), 32'd0);
        rst = 1'b0;

        ramp();
        run(24'd36, 0, 1'b0, 1'b0);

        ramp();
        stall_addr = 32'h08;
        stall_left = 3;
        run(24'd36, 3, 1'b0, 1'b0);
        stall_left = 0;

        ramp();
        run(24'd35, 0, 1'b1, 1'b0);

        for (int i = 0; i < DEPTH; i++) cv[i] = 24'hFFFFFF;
        run(24'hFFFFF8, 0, 1'b0, 1'b0);
        check("err_cleared", 32'(sum_err), 32'd0);

        ramp();
        run(24'd36, 0, 1'b0, 1'b1);

        // Reset and start on the same edge: reset must win.
        ramp();
        @(negedge clk); #2;
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk); #2;
        rst   = 1'b0;
        start = 1'b0;
        check("rst_start_busy", 32'(busy), 32'd0);
        @(negedge clk); #2;
        check("rst_start_idle", 32'(busy), 32'd0);

        // Reset while element 4 is stalled.
        ramp();
        n_wr       = 0;
        stall_addr = 32'h10;
        stall_left = 5;
        sum_in     = 24'd36;
        push_exp(24'd36);
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus.write && bus.address == 32'h10 && bus.waitrequest) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk); #2;
        end
        check("stall4_seen", 32'(seen), 32'd1);
        rst = 1'b1;
        @(negedge clk); #2;
        rst = 1'b0;
        stall_left = 0;
        exp_q.delete();
        check("mid_rst_write", 32'(bus.write), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk); #2;
            if (done || bus.write) seen = 1'b1;
        end
        check("mid_rst_quiet", 32'(seen), 32'd0);
        check("mid_rst_nwr", 32'(n_wr), 32'd4);
        stall_addr = 32'hFFFF_FFFF;

        ramp();
        run(24'd36, 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
